// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial wide adder sequencing an external 4-bit adder
// Optional macro NIBBLE_SERIAL_ADDER_SUB_EN adds a 'sub' input for A - B.

module fulladder_4bit (
    output logic [3:0] S,
    output logic       Co,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci
);
    assign {Co, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic                   sub,
`endif
    output logic [3:0]             adder_a,
    output logic [3:0]             adder_b,
    output logic                   adder_ci,
    input  logic [3:0]             adder_s,
    input  logic                   adder_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            sub_mode;
    logic [W+3:0]    sum_shift;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign sub_mode = sub;
`else
    assign sub_mode = 1'b0;
`endif

    // New nibble enters at the top so nibble 0 lands at sum[3:0] after the last step.
    assign sum_shift = {adder_s, sum_q};

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d     = op_a;
                    b_sh_d     = sub_mode ? ~op_b : op_b;
                    carry_d    = sub_mode ? 1'b1 : cin;
                    cnt_d      = '0;
                    sum_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                sum_d   = sum_shift[W+3:4];
                carry_d = adder_co;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d      = adder_co;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign adder_a   = a_sh_q[3:0];
    assign adder_b   = b_sh_q[3:0];
    assign adder_ci  = carry_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
